de3cd_sysctrl_axil_regs: RTL
============================

DE3CD_SYSCTRL_AXIL_REGS -- requirements
Module: de3cd_sysctrl_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 word registers.
REQ-003 SHALL have port ACLK, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port ARESET, input, 1; one clock, reset asynchronous and active-high.
REQ-005 SHALL have ports S_AXI_AWADDR in 4, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have ports S_AXI_ARADDR in 4, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-010 SHALL have ports reg0_out..reg3_out, out, 32 each, current register contents to fabric.
REQ-011 SHALL have port reg_wr_pulse, out, 4, one-cycle strobe per register on write commit.

Function
REQ-012 SHALL decode register index from address bits [3:2]; bits [1:0] ignored; all four indices map to RW registers.
REQ-013 Write FSM SHALL have states W_ACCEPT and W_RESP; AWREADY=1 in W_ACCEPT while no AW held; WREADY=1 in W_ACCEPT while no W held.
REQ-014 AW and W SHALL be accepted independently in any order or same cycle; an accepted address/data is held internally until its partner arrives.
REQ-015 On the edge where the second of AW/W completes (or both on one edge), the write SHALL commit: byte lane n updated iff WSTRB[n]=1; FSM enters W_RESP.
REQ-016 In W_RESP BVALID=1, BRESP=2'b00, AWREADY=WREADY=0; on BVALID&BREADY edge FSM returns to W_ACCEPT, BVALID=0 next cycle.
REQ-017 reg_wr_pulse[idx] SHALL be 1 for exactly the cycle following the commit edge, even when WSTRB=0 (register unchanged).
REQ-018 Read FSM SHALL have states R_ACCEPT and R_DATA; ARREADY=1 only in R_ACCEPT.
REQ-019 On AR handshake RDATA SHALL latch register[ARADDR[3:2]] value present before that edge; RVALID=1, RRESP=2'b00 next cycle; RDATA stable while RVALID&!RREADY.
REQ-020 On RVALID&RREADY edge read FSM SHALL return to R_ACCEPT; minimum read throughput one transaction per 2 cycles.
REQ-021 Read and write FSMs SHALL be independent; write commit and read capture of same register on same edge returns pre-write value.
REQ-022 reg*_out SHALL reflect committed values the cycle after commit; no combinational path from AXI inputs to any output.
REQ-023 BVALID/RVALID SHALL NOT deassert before their respective READY handshake.

Reset
REQ-024 While ARESET=1: all registers, reg*_out, reg_wr_pulse, RDATA=0; all VALID and READY outputs=0; FSMs in W_ACCEPT/R_ACCEPT; held AW/W discarded.
REQ-025 First rising edge after ARESET deasserts SHALL raise AWREADY, WREADY, ARREADY.
REQ-026 Reset mid-transaction SHALL abort it without commit; no BVALID/RVALID after release for the aborted transfer.

Verification
REQ-027 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, WSTRB=0xF, BREADY=1 -> each BRESP=00; read back the four addresses -> RDATA 0x1..0x4, RRESP=00.
REQ-028 W presented 3 cycles before AW to 0x8, data 0xDEADBEEF -> WREADY drops after W handshake, commit on AW edge, reg2_out=0xDEADBEEF, reg_wr_pulse=4'b0100 one cycle.
REQ-029 reg1=0xFFFFFFFF, write 0x12345678 WSTRB=4'b0101 to 0x4 -> reg1_out=0xFF34FF78.
REQ-030 BREADY held 0 for 5 cycles after commit -> BVALID stays 1, AWREADY/WREADY stay 0; next write accepted only after B handshake.
REQ-031 Same-edge write 0xA5A5A5A5 commit and AR of 0xC (old 0x4) -> RDATA=0x4, subsequent read -> 0xA5A5A5A5.
REQ-032 Assert ARESET with AW accepted, W pending -> after release all regs 0, no BVALID, AWREADY=WREADY=ARREADY=1 one edge after release.

Source files
------------

// File: rtl/de3cd_sysctrl_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write control registers.
// The write channel accepts AW and W independently, holds whichever arrives
// first and commits on the edge where both are present. The read channel
// latches the addressed register on the AR handshake. Every output comes
// straight from a flop, so no AXI input reaches an output combinationally.
module de3cd_sysctrl_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response channel
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // fabric side
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out,
    output logic [3:0]                      reg_wr_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int NUM_REGS = 4;
    localparam int ADDR_LSB = 2;

    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_RESP   = 1'b1
    } wstate_t;

    typedef enum logic {
        R_ACCEPT = 1'b0,
        R_DATA   = 1'b1
    } rstate_t;

    genvar gi;
    genvar gj;

    // write channel state
    wstate_t                  wstate_q, wstate_d;
    logic                     aw_held_q, aw_held_d;
    logic [1:0]               aw_idx_q, aw_idx_d;
    logic                     w_held_q, w_held_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;
    logic                     awready_q, awready_d;
    logic                     wready_q, wready_d;
    logic [NUM_REGS-1:0]      wr_pulse_q, wr_pulse_d;

    // register file
    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;

    // read channel state
    rstate_t                  rstate_q, rstate_d;
    logic                     arready_q, arready_d;
    logic [DW-1:0]            rdata_q, rdata_d;

    // handshake and commit decode
    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     commit;
    logic [1:0]               wr_idx;
    logic [DW-1:0]            wr_data;
    logic [STRB_W-1:0]        wr_strb;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Readies are registered, so a handshake is simply VALID while READY is high.
    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;

    // A freshly arriving beat takes priority over a held copy when forming the commit.
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[ADDR_LSB+1:ADDR_LSB] : aw_idx_q;
    assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
    assign commit  = (wstate_q == W_ACCEPT) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // Write FSM next state: hold the first-arriving half, commit when both are present.
    always_comb begin
        wstate_d   = wstate_q;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_pulse_d = '0;
        case (wstate_q)
            W_ACCEPT: begin
                if (commit) begin
                    wstate_d           = W_RESP;
                    aw_held_d          = 1'b0;
                    w_held_d           = 1'b0;
                    wr_pulse_d[wr_idx] = 1'b1;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = S_AXI_AWADDR[ADDR_LSB+1:ADDR_LSB];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d = W_ACCEPT;
                end
            end
            default: begin
                wstate_d = W_ACCEPT;
            end
        endcase
        // Readies look one state ahead so they are valid straight out of the flop.
        awready_d = (wstate_d == W_ACCEPT) && !aw_held_d;
        wready_d  = (wstate_d == W_ACCEPT) && !w_held_d;
    end

    // Write FSM and holding registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q   <= W_ACCEPT;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Byte-lane merge: a lane changes only on a commit to its register with its strobe set.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            for (gj = 0; gj < STRB_W; gj++) begin : g_lane
                assign regs_d[gi][8*gj +: 8] =
                    (commit && (wr_idx == 2'(gi)) && wr_strb[gj]) ? wr_data[8*gj +: 8]
                                                                   : regs_q[gi][8*gj +: 8];
            end
        end
    endgenerate

    // Register file storage.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read FSM next state: capture the pre-edge register value on the AR handshake.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_ACCEPT: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rdata_d  = regs_q[S_AXI_ARADDR[ADDR_LSB+1:ADDR_LSB]];
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rstate_d = R_ACCEPT;
                end
            end
            default: begin
                rstate_d = R_ACCEPT;
            end
        endcase
        arready_d = (rstate_d == R_ACCEPT);
    end

    // Read FSM and read data register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q  <= R_ACCEPT;
            arready_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = (wstate_q == W_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (rstate_q == R_DATA);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata_q;

    assign reg0_out      = regs_q[0];
    assign reg1_out      = regs_q[1];
    assign reg2_out      = regs_q[2];
    assign reg3_out      = regs_q[3];
    assign reg_wr_pulse  = wr_pulse_q;

endmodule
